sirv_jtag_pinport_os: RTL

//  Parametrised successor of the JTAG pin port: oversamples the five JTAG pads on the system clock and feeds an oversampled TAP.
//  - Synchronises TCK/TMS/TDI/TRST_n and detects TCK edges.
//  - Glitch-filters TRST_n and registers TDO on TCK falling edges.
//  - Drives all pad controls.

---
 rtl/sirv_jtag_pinport_os_if.sv | 49 ++++
 rtl/sirv_jtag_pinport_os.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sirv_jtag_pinport_os_if.sv
// Pad-ring and TAP-side signal bundle for the oversampled JTAG pin port.
// The slave modport is the pin port; the master modport is the pad ring plus TAP environment.
interface sirv_jtag_pinport_os_if;
    logic [4:0] pad_ival;
    logic [4:0] pad_oval;
    logic [4:0] pad_oe;
    logic [4:0] pad_ie;
    logic [4:0] pad_pue;
    logic [4:0] pad_ds;
    logic       jtag_tck_rise;
    logic       jtag_tck_fall;
    logic       jtag_tms;
    logic       jtag_tdi;
    logic       jtag_trst;
    logic       jtag_tdo;
    logic       jtag_drv_tdo;

    modport slave (
        input  pad_ival,
        output pad_oval,
        output pad_oe,
        output pad_ie,
        output pad_pue,
        output pad_ds,
        output jtag_tck_rise,
        output jtag_tck_fall,
        output jtag_tms,
        output jtag_tdi,
        output jtag_trst,
        input  jtag_tdo,
        input  jtag_drv_tdo
    );

    modport master (
        output pad_ival,
        input  pad_oval,
        input  pad_oe,
        input  pad_ie,
        input  pad_pue,
        input  pad_ds,
        input  jtag_tck_rise,
        input  jtag_tck_fall,
        input  jtag_tms,
        input  jtag_tdi,
        input  jtag_trst,
        output jtag_tdo,
        output jtag_drv_tdo
    );
endinterface

// File: rtl/sirv_jtag_pinport_os.sv
// Oversampling JTAG pin port: synchronises the JTAG pads on clk, produces TCK edge
// strobes for an oversampled TAP, glitch-filters TRST_n and launches TDO on TCK falls.
//
// TRST filter states:
//   state        | meaning
//   ST_ASSERTED  | TAP held in reset, waiting for synced TRST_n to go high
//   ST_RELEASING | TRST_n high, counting stable cycles before releasing the TAP
//   ST_RUN       | TAP released, counting consecutive low cycles to re-assert
module sirv_jtag_pinport_os #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 8,
    parameter bit          USE_TRST    = 1'b1,
    parameter logic [4:0]  PUE_MASK    = 5'h17,
    parameter logic [4:0]  DS_MASK     = 5'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sirv_jtag_pinport_os_if.slave  pins
);

    localparam int unsigned       CNT_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  FILT_MAX = CNT_W'(FILT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // Synchroniser bit order {TRST_n, TDI, TMS, TCK}; TRST_n resets low so the TAP starts in reset
    localparam logic [3:0]        SYNC_RST = 4'b0110;

    typedef enum logic [1:0] {
        ST_ASSERTED  = 2'd0,
        ST_RELEASING = 2'd1,
        ST_RUN       = 2'd2
    } trst_state_e;

    logic [3:0]       pad_smp;
    logic [3:0]       sync_q [SYNC_STAGES];
    logic             tck_s;
    logic             tms_s;
    logic             tdi_s;
    logic             trst_n_s;

    logic             tck_d_q;
    logic             rise_d;
    logic             fall_d;
    logic             rise_q;
    logic             fall_q;
    logic             tms_q;
    logic             tdi_q;

    trst_state_e      state_q;
    trst_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             trst_act;

    logic             tdo_q;
    logic             tdo_d;
    logic             oe_q;
    logic             oe_d;

    logic             unused_pad_tdo;

    assign pad_smp        = {pins.pad_ival[4], pins.pad_ival[2:0]};
    assign unused_pad_tdo = pins.pad_ival[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
        end else begin
            sync_q[0] <= pad_smp;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign tck_s    = sync_q[SYNC_STAGES-1][0];
    assign tms_s    = sync_q[SYNC_STAGES-1][1];
    assign tdi_s    = sync_q[SYNC_STAGES-1][2];
    assign trst_n_s = USE_TRST ? sync_q[SYNC_STAGES-1][3] : 1'b1;

    // TMS/TDI are re-registered alongside the edge strobes so the TAP sees the
    // data that was on the pads in the same sample as the TCK transition.
    assign rise_d = tck_s & ~tck_d_q;
    assign fall_d = ~tck_s & tck_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_d_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b1;
        end else begin
            tck_d_q <= tck_s;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tms_q   <= tms_s;
            tdi_q   <= tdi_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        trst_act = 1'b1;
        case (state_q)
            ST_ASSERTED: begin
                if (trst_n_s) begin
                    state_d = ST_RELEASING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASING: begin
                if (!trst_n_s) begin
                    state_d = ST_ASSERTED;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_MAX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                trst_act = 1'b0;
                // Re-assert on the cycle that completes FILT_CYCLES consecutive low samples
                if (!trst_n_s) begin
                    if (cnt_inc == FILT_MAX) begin
                        state_d = ST_ASSERTED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_ASSERTED;
                cnt_d   = '0;
            end
        endcase
    end

    assign tdo_d = fall_q ? pins.jtag_tdo     : tdo_q;
    assign oe_d  = fall_q ? pins.jtag_drv_tdo : oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q <= 1'b0;
            oe_q  <= 1'b0;
        end else begin
            tdo_q <= tdo_d;
            oe_q  <= oe_d;
        end
    end

    assign pins.jtag_tck_rise = rise_q;
    assign pins.jtag_tck_fall = fall_q;
    assign pins.jtag_tms      = tms_q;
    assign pins.jtag_tdi      = tdi_q;
    assign pins.jtag_trst     = trst_act;

    // The TDO driver is masked while the TAP is in reset, even if a fall updated oe_q
    assign pins.pad_oval = {1'b0, tdo_q, 3'b000};
    assign pins.pad_oe   = {1'b0, oe_q & ~trst_act, 3'b000};
    assign pins.pad_ie   = {USE_TRST, 1'b0, 3'b111};
    assign pins.pad_pue  = PUE_MASK;
    assign pins.pad_ds   = DS_MASK;

endmodule
